// File: rtl/rv_trace_if.sv
// Trace-buffer bundle: capture strobes from the core plus the FWFT drain port and status.
// slave is the buffer side, master is the core/host side.
interface rv_trace_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) ();
  logic                     rf_we;
  logic [4:0]               rf_rd;
  logic [XLEN-1:0]          rf_wdata;
  logic                     mem_we;
  logic [XLEN-1:0]          mem_addr;
  logic [XLEN-1:0]          mem_wdata;
  logic [XLEN-1:0]          pc;
  logic [XLEN-1:0]          old_pc;
  logic [31:0]              instr;
  logic                     rd_en;
  logic                     rd_valid;
  logic [2+3*XLEN-1:0]      rd_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     jal_err;
  logic [CNT_W-1:0]         jal_err_cnt;
  logic [CNT_W-1:0]         cycle_cnt;
  logic [1:0]               state;
  logic                     done;

  modport slave (
    input  rf_we, rf_rd, rf_wdata, mem_we, mem_addr, mem_wdata, pc, old_pc, instr, rd_en,
    output rd_valid, rd_data, count, overflow, drop_cnt, jal_err, jal_err_cnt, cycle_cnt,
           state, done
  );

  modport master (
    output rf_we, rf_rd, rf_wdata, mem_we, mem_addr, mem_wdata, pc, old_pc, instr, rd_en,
    input  rd_valid, rd_data, count, overflow, drop_cnt, jal_err, jal_err_cnt, cycle_cnt,
           state, done
  );
endinterface

// File: rtl/rv_trace_buffer.sv
// Retirement-trace capture for rv_mc: circular FWFT FIFO of reg/store/JAL/end entries,
// JAL link checking, cycle counting and halt/watchdog detection.
module rv_trace_buffer #(
  parameter int              XLEN    = 32,
  parameter int              DEPTH   = 16,
  parameter logic [XLEN-1:0] END_PC  = XLEN'(32'h58),
  parameter int              TIMEOUT = 10000,
  parameter int              CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  rv_trace_if.slave  trc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 + 3 * XLEN;

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_HALTED  = 2'b01,
    S_TIMEOUT = 2'b10
  } state_t;

  state_t            st;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CNT_W-1:0]  cyc, drops, jal_errs;
  logic              ovf, jal_flag;

  logic              run, hit_halt, hit_tmo, end_ev, rf_cap, is_jal;
  logic              push_req, push_ok, pop, full, store_drop, jal_bad;
  logic [1:0]        n_drop;
  logic [EW-1:0]     entry;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    run        = (st == S_RUN);
    hit_halt   = (trc.pc >= END_PC);
    hit_tmo    = (cyc == CNT_W'(TIMEOUT));
    end_ev     = run && (hit_halt || hit_tmo);
    rf_cap     = trc.rf_we && (trc.rf_rd != 5'd0);
    is_jal     = (trc.instr[6:0] == 7'b1101111);
    push_req   = end_ev || (run && (rf_cap || trc.mem_we));
    // A store colliding with a captured reg write loses its slot regardless of FIFO space.
    store_drop = run && !end_ev && rf_cap && trc.mem_we;
    pop        = trc.rd_en && (cnt != '0);
    full       = (cnt == CW'(DEPTH));
    push_ok    = push_req && (!full || pop);
    n_drop     = {1'b0, push_req && !push_ok} + {1'b0, store_drop};
    jal_bad    = run && trc.rf_we && is_jal && (trc.rf_wdata != trc.old_pc + XLEN'(4));

    entry = '0;
    if (end_ev)
      entry = {2'b11, trc.pc, XLEN'(cyc), (hit_halt ? XLEN'(0) : XLEN'(1))};
    else if (rf_cap)
      entry = {(is_jal ? 2'b10 : 2'b00), trc.pc, XLEN'(trc.rf_rd), trc.rf_wdata};
    else
      entry = {2'b01, trc.pc, trc.mem_addr, trc.mem_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      cyc      <= '0;
      drops    <= '0;
      jal_errs <= '0;
      ovf      <= 1'b0;
      jal_flag <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop);
      if (n_drop != 2'd0) begin
        drops <= sat_add(drops, n_drop);
        ovf   <= 1'b1;
      end
      if (jal_bad) begin
        jal_errs <= sat_add(jal_errs, 2'd1);
        jal_flag <= 1'b1;
      end
      // The end edge leaves cycle_cnt at the value recorded in the marker.
      if (run && !end_ev) cyc <= sat_add(cyc, 2'd1);
      if (run && hit_halt)     st <= S_HALTED;
      else if (run && hit_tmo) st <= S_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= entry;
  end

  assign trc.rd_valid    = (cnt != '0);
  assign trc.rd_data     = (cnt != '0) ? mem[rd_ptr] : '0;
  assign trc.count       = cnt;
  assign trc.overflow    = ovf;
  assign trc.drop_cnt    = drops;
  assign trc.jal_err     = jal_flag;
  assign trc.jal_err_cnt = jal_errs;
  assign trc.cycle_cnt   = cyc;
  assign trc.state       = st;
  assign trc.done        = (st != S_RUN);
endmodule
